// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller.
//   S_*      : controller state encodings
//   NREQ_MAX : largest supported requester count
//   onehot() : index -> one-hot vector of NREQ_MAX bits
package mul_share_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned STW      = 3;

    localparam logic [STW-1:0] S_IDLE   = 3'd0;
    localparam logic [STW-1:0] S_LOAD_A = 3'd1;
    localparam logic [STW-1:0] S_LOAD_B = 3'd2;
    localparam logic [STW-1:0] S_ACC    = 3'd3;
    localparam logic [STW-1:0] S_DONE   = 3'd4;

    // One-hot vector with bit idx set.
    function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
        onehot = NREQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// Combinational round-robin winner selection.
//   req   : request vector
//   ptr   : highest-priority index for this decision
//   valid : at least one request is set
//   idx   : first set request at ptr, ptr+1, ... (mod NREQ)
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned SELW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            valid,
    output logic [SELW-1:0] idx
);

    int unsigned     cand;
    logic [SELW-1:0] ci;

    // Scan from the lowest priority offset down so the highest priority hit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        ci    = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            cand = (32'(ptr) + 32'(i)) % NREQ;
            ci   = SELW'(cand);
            if (req[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Sequencer + round-robin arbiter sharing one repeated-addition multiplier.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request level (held until done)
//   gnt      : registered one-hot grant, held for the whole operation
//   done     : registered one-cycle pulse to the winner (P valid)
//   sel      : registered operand mux select (winner index)
//   busy     : registered, high outside IDLE
//   ldA, ldB, clrP, ldP, decB : datapath strobes decoded from state (and eqz)
//   eqz      : datapath flag, registered B == 0
// Build option: define MUL_SHARE_ABORT_EN to abort an operation whose
// requester drops req before completion (clrP pulse, no done).
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            ldA,
    output logic            ldB,
    output logic            clrP,
    output logic            ldP,
    output logic            decB,
    input  logic            eqz
);

    logic [STW-1:0]  state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic [SELW-1:0] sel_nxt, sel_inc;
    logic            busy_nxt;
    logic            pick_valid;
    logic [SELW-1:0] pick_idx;

    rr_pick #(.NREQ(NREQ), .SELW(SELW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            gnt   <= '0;
            done  <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next state, registered-output next values and strobe decode.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        done_nxt  = '0;
        busy_nxt  = busy;
        ldA       = 1'b0;
        ldB       = 1'b0;
        clrP      = 1'b0;
        ldP       = 1'b0;
        decB      = 1'b0;
        sel_inc   = (32'(sel) == NREQ - 1) ? '0 : sel + SELW'(1);

        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_nxt   = NREQ'(onehot(3'(pick_idx)));
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                ldA       = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                ldB       = 1'b1;
                clrP      = 1'b1;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                ldP  = ~eqz;
                decB = ~eqz;
                if (eqz) begin
                    done_nxt  = NREQ'(onehot(3'(sel)));
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                ptr_nxt   = sel_inc;
                state_nxt = S_IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

`ifdef MUL_SHARE_ABORT_EN
        // Winner withdrew before completion: clear P and release without done.
        if ((state == S_LOAD_A || state == S_LOAD_B || state == S_ACC) && !req[sel]) begin
            ldA       = 1'b0;
            ldB       = 1'b0;
            ldP       = 1'b0;
            decB      = 1'b0;
            clrP      = 1'b1;
            done_nxt  = '0;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            ptr_nxt   = sel_inc;
            state_nxt = S_IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed self-checking bench for mul_share_ctrl (NREQ=2) with a small
// repeated-addition datapath model driven by the controller strobes.
module tb_mul_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt, done;
    logic [0:0] sel;
    logic       busy, ldA, ldB, clrP, ldP, decB, eqz;

    logic [15:0] opa [2];
    logic [15:0] opb [2];
    logic [15:0] ra, rb, rp;

    int checks = 0;
    int errors = 0;
    int n;
    logic saw_acc, sel_bad, gnt_multi;

    always #5 clk = ~clk;

    mul_share_ctrl #(.NREQ(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .done (done),
        .sel  (sel),
        .busy (busy),
        .ldA  (ldA),
        .ldB  (ldB),
        .clrP (clrP),
        .ldP  (ldP),
        .decB (decB),
        .eqz  (eqz)
    );

    // Datapath model: A, B (decrementing), P accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra <= '0;
            rb <= '0;
            rp <= '0;
        end else begin
            if (ldA)       ra <= opa[sel];
            if (ldB)       rb <= opb[sel];
            else if (decB) rb <= rb - 16'd1;
            if (clrP)      rp <= '0;
            else if (ldP)  rp <= rp + ra;
        end
    end
    assign eqz = (rb == 16'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {ldA, ldB, clrP, ldP, decB};
    endfunction

    // Step until done is seen or a cycle budget expires; tracks side flags.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
            if (ldP || decB) saw_acc = 1'b1;
            if (busy && sel != 1'b1) sel_bad = 1'b1;
            if (gnt == 2'b11) gnt_multi = 1'b1;
        end while (done == 2'b00 && cnt < 40);
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b11;
        opa[0] = 16'd5; opb[0] = 16'd3;
        opa[1] = 16'd9; opb[1] = 16'd0;
        saw_acc = 1'b0; sel_bad = 1'b0; gnt_multi = 1'b0;

        // Reset with both requesting.
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_strobes", 32'(strobes()), 32'h0);
        rst = 1'b0;
        step();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
        step();

        // Single multiply 5*3 on requester 0.
        req = 2'b01;
        step();
        chk("mul_s1_gnt", 32'(gnt), 32'h1);
        chk("mul_s1_busy", 32'(busy), 32'h1);
        chk("mul_s1_strb", 32'(strobes()), 32'h10);
        step();
        chk("mul_s2_strb", 32'(strobes()), 32'h0c);
        step();
        chk("mul_s3_strb", 32'(strobes()), 32'h03);
        step();
        chk("mul_s4_strb", 32'(strobes()), 32'h03);
        step();
        chk("mul_s5_strb", 32'(strobes()), 32'h03);
        step();
        chk("mul_s6_strb", 32'(strobes()), 32'h00);
        chk("mul_s6_done", 32'(done), 32'h0);
        step();
        chk("mul_s7_done", 32'(done), 32'h1);
        chk("mul_s7_strb", 32'(strobes()), 32'h00);
        chk("mul_p", 32'(rp), 32'd15);
        req = 2'b00;
        step();
        chk("mul_idle_busy", 32'(busy), 32'h0);
        chk("mul_idle_gnt", 32'(gnt), 32'h0);
        chk("mul_done_pulse", 32'(done), 32'h0);

        // B = 0 on requester 1.
        req = 2'b10;
        saw_acc = 1'b0; sel_bad = 1'b0;
        wait_done(n);
        chk("bz_latency", 32'(n), 32'd4);
        chk("bz_done", 32'(done), 32'h2);
        chk("bz_p", 32'(rp), 32'd0);
        chk("bz_no_acc", 32'(saw_acc), 32'h0);
        chk("bz_sel", 32'(sel_bad), 32'h0);
        req = 2'b00;
        step();

        // Contention: four operations, alternating winners.
        opa[0] = 16'd3; opb[0] = 16'd2;
        opa[1] = 16'd4; opb[1] = 16'd2;
        req = 2'b11;
        gnt_multi = 1'b0;
        wait_done(n);
        chk("ct1_done", 32'(done), 32'h1);
        chk("ct1_p", 32'(rp), 32'd6);
        wait_done(n);
        chk("ct2_done", 32'(done), 32'h2);
        chk("ct2_p", 32'(rp), 32'd8);
        wait_done(n);
        chk("ct3_done", 32'(done), 32'h1);
        chk("ct3_p", 32'(rp), 32'd6);
        wait_done(n);
        chk("ct4_done", 32'(done), 32'h2);
        chk("ct4_p", 32'(rp), 32'd8);
        chk("ct_onehot", 32'(gnt_multi), 32'h0);
        req = 2'b00;
        step();
        chk("ct_idle", 32'(busy), 32'h0);

        // Winner drops req during ACC.
        opa[0] = 16'd7; opb[0] = 16'd4;
        req = 2'b01;
        step();
        step();
        step();
        req = 2'b00;
`ifdef MUL_SHARE_ABORT_EN
        #1;
        chk("ab_strb", 32'(strobes()), 32'h04);
        step();
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_gnt", 32'(gnt), 32'h0);
        chk("ab_done", 32'(done), 32'h0);
`else
        wait_done(n);
        chk("drop_done", 32'(done), 32'h1);
        chk("drop_p", 32'(rp), 32'd28);
        step();
`endif
        req = 2'b11;
        step();
        chk("drop_next_gnt", 32'(gnt), 32'h2);

        // Reset in the middle of ACC.
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
        opa[0] = 16'd3; opb[0] = 16'd6;
        req = 2'b01;
        step();
        step();
        step();
        step();
        step();
        chk("mr_pre_acc", 32'(strobes()), 32'h03);
        chk("mr_pre_p", 32'(rp), 32'd6);
        rst = 1'b1;
        req = 2'b00;
        step();
        chk("mr_strb", 32'(strobes()), 32'h00);
        chk("mr_gnt", 32'(gnt), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("mr_quiet_done", 32'(done), 32'h0);
        chk("mr_quiet_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencer plus round-robin arbiter that shares one repeated-addition multiplier datapath among NREQ requesters.
- The datapath holds registers A, B (decrementing) and P (accumulator), and reports eqz when B==0.
- The datapath operand mux is driven by `sel`. This block grants one requester, drives the datapath load/clear/decrement strobes until B reaches zero, then pulses that requester's done.
- The product is read by the winner from the shared P bus on its done pulse.

Parameters:
- NREQ, 2, number of requesters (2..8).
- SELW, $clog2(NREQ) (min 1), width of sel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high; one clock, clk.
- req  input  NREQ  per-requester request. Requester holds it high until its done.
- gnt  output  NREQ  one-hot grant, held for the whole operation.
- done  output  NREQ  one-cycle pulse to the winner; P is valid that cycle.
- sel  output  SELW  operand mux select (winner index).
- busy  output  1  high in every state except IDLE.
- ldA  output  1  load A from selected operand.
- ldB  output  1  load B from selected operand.
- clrP  output  1  clear P.
- ldP  output  1  P <= P + A.
- decB  output  1  B <= B - 1.
- eqz  input  1  datapath flag, B==0 (reflects registered B).

Behaviour:
- Reset: state=IDLE, ptr=0, and gnt, done, sel, busy, ldA, ldB, clrP, ldP, decB all 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, LOAD_A, LOAD_B, ACC, DONE. gnt, sel, done and busy are registered. Strobes are decoded from state (ACC strobes also use eqz).
- IDLE: all strobes 0.
  - If |req, pick the winner by round-robin starting at ptr (first set bit at index ptr, ptr+1, ... mod NREQ).
  - Register gnt=onehot(w) and sel=w, then go to LOAD_A.
  - Else stay in IDLE.
- LOAD_A: ldA=1 -> LOAD_B.
- LOAD_B: ldB=1, clrP=1 (same edge) -> ACC.
- ACC:
  - ldP = decB = ~eqz.
  - If eqz, go to DONE. Else stay in ACC.
  - B==0 at load therefore gives zero accumulate cycles, so P=0.
- DONE: done[sel]=1 for exactly one cycle, no strobes. Next edge: gnt=0, busy=0, ptr=(sel+1) mod NREQ -> IDLE.
- Latency from grant edge to done cycle is B+3 cycles. Total clk from req sampled in IDLE to done high is B+4.
- Arbitration:
  - New requests arriving during busy are queued only by their level; they are evaluated only in IDLE.
  - Simultaneous requests are resolved by ptr, so no starvation: each requester waits at most NREQ-1 operations.
- req drop by the winner mid-operation is ignored; the operation completes and done still pulses (unless MUL_SHARE_ABORT_EN).
- gnt bits other than the winner are always 0. gnt and sel are stable from LOAD_A through DONE.
- At most one strobe group is active per cycle; ldA/ldB never coincide with ldP/decB.
- eqz in states other than ACC is ignored.

Optional Feature:
- MUL_SHARE_ABORT_EN defined:
  - In LOAD_A, LOAD_B or ACC, if req[sel]==0 the controller asserts clrP=1 (other strobes 0) for one cycle and goes to IDLE.
  - No done pulse is produced; gnt clears on the same edge; ptr advances past the aborted requester.
- Undefined: req drop is ignored, as above.

Decomposition:
- Shared package mul_share_pkg:
  - state encoding constants S_IDLE=3'd0, S_LOAD_A=3'd1, S_LOAD_B=3'd2, S_ACC=3'd3, S_DONE=3'd4.
  - NREQ_MAX=8.
  - One-hot/index helper function.
- Sub-module rr_pick: combinational round-robin winner selection from req and ptr, producing a valid flag and index. Pointer storage stays in mul_share_ctrl.

Test Plan:
- Reset: assert rst for 2 cycles with req=2'b11 -> all outputs 0, busy=0. After release, requester 0 wins (ptr=0).
- Single multiply: req=2'b01, datapath operands A=5, B=3.
  - Required: ldA, then ldB+clrP, then 3 cycles of ldP+decB, then done[0] with P=15.
  - done exactly 7 cycles after req is sampled.
- B=0: req=2'b10, B=0 -> no ldP/decB cycles, done[1] after 4 cycles, P=0, sel=1 throughout.
- Contention: req=2'b11 held for 4 operations (B=2 each) -> grants alternate 0,1,0,1 and done pulses alternate. Never two gnt bits set.
- Mid-operation req drop with the macro undefined (A=7, B=4, drop req[0] in ACC) -> operation finishes, done[0] pulses, P=28.
  - With MUL_SHARE_ABORT_EN: one-cycle clrP, no done, return to IDLE, next grant goes to requester 1.
- Reset mid-ACC (A=3, B=6, rst after 2 accumulates) -> next cycle all strobes, gnt, busy=0, no done pulse.
